// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: two requester ports plus the memory port.
// The slave modport is the arbiter's view. The master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Requester 0 (core load/store path)
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  // Requester 1 (debug/loader port)
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          lock1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  // Data memory port
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_wren, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_wren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one registered-read data memory port between the core (req 0)
// and a debug/loader port (req 1) that may lock the port for bounded bursts.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LockMax = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [0:0] {StRr, StLocked} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          gnt0, gnt1;
  logic          rr_last;
  logic          lock_limit;
  logic          rvalid0, rvalid1;

  // Grant decode and arbitration state
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rr_last    = last_q;
    lock_limit = (LOCK_MAX != 0) && (lock_cnt_q >= LockMax);

    if (state_q == StLocked && bus.lock1) begin
      // Past the limit requester 1 keeps the port only while requester 0 is idle.
      if (lock_limit && bus.req0) begin
        gnt0       = 1'b1;
        state_d    = StRr;
        lock_cnt_d = '0;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
        if (!lock_limit) begin
          lock_cnt_d = lock_cnt_q + CntOne;
        end
      end
    end else begin
      // Leaving a lock arbitrates as if requester 1 just won.
      rr_last = (state_q == StLocked) ? 1'b1 : last_q;
      if (bus.req0 && (!bus.req1 || rr_last)) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
      state_d    = StRr;
      lock_cnt_d = '0;
      if (gnt1 && bus.lock1) begin
        state_d    = StLocked;
        lock_cnt_d = CntOne;
      end
    end

    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  // Read-return tracking: a single outstanding read, returned the cycle after its grant
  always_comb begin
    rd_pend_d  = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
    rd_owner_d = rd_pend_d ? gnt1 : rd_owner_q;
    rvalid0    = rd_pend_q && !rd_owner_q;
    rvalid1    = rd_pend_q && rd_owner_q;
    rdata0_d   = rvalid0 ? bus.mem_rdata : rdata0_q;
    rdata1_d   = rvalid1 ? bus.mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRr;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0;
  assign bus.rvalid1   = rvalid1;
  assign bus.rdata0    = rdata0_d;
  assign bus.rdata1    = rdata1_d;
  assign bus.mem_wren  = gnt0 ? bus.we0    : (gnt1 ? bus.we1    : 1'b0);
  assign bus.mem_addr  = gnt0 ? bus.addr0  : (gnt1 ? bus.addr1  : '0);
  assign bus.mem_wdata = gnt0 ? bus.wdata0 : (gnt1 ? bus.wdata1 : '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter: a rule-level arbitration model predicts
// grants and read data, and a separate monitor checks read returns from a scoreboard.
module tb_dmem_arbiter;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int          LockMax = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LockMax)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device with registered read
  logic [DW-1:0] dev_mem [256];
  logic [DW-1:0] ref_mem [256];
  always @(posedge clk) begin
    if (bus.mem_wren) dev_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= dev_mem[bus.mem_addr[7:0]];
  end

  typedef struct {int due; bit owner; logic [DW-1:0] data;} rd_t;
  rd_t sb[$];

  // Reference model state
  int m_last   = 1;
  bit m_locked = 0;
  int m_burst  = 0;
  int wait0    = 0;
  int wait1    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int model_winner(bit q0, bit q1, bit l1);
    int lastw;
    if (m_locked && l1) begin
      if (m_burst >= LockMax && q0) return 0;
      return q1 ? 1 : -1;
    end
    lastw = m_locked ? 1 : m_last;
    if (q0 && q1) return (lastw == 1) ? 0 : 1;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  task automatic model_update(input int w, input bit l1);
    if (m_locked && l1) begin
      if (w == 0) begin
        m_locked = 0;
        m_burst  = 0;
      end else if (w == 1) begin
        m_burst++;
      end
    end else begin
      m_locked = (w == 1) && l1;
      m_burst  = m_locked ? 1 : 0;
    end
    if (w >= 0) m_last = w;
  endtask

  task automatic model_reset();
    m_last   = 1;
    m_locked = 0;
    m_burst  = 0;
    wait0    = 0;
    wait1    = 0;
    sb.delete();
  endtask

  // Inputs are already on the bus; check this cycle's grant and advance to just past the edge.
  task automatic step(output int w);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ewe;
    @(negedge clk);
    w = model_winner(bus.req0, bus.req1, bus.lock1);
    check("gnt0", bus.gnt0, w == 0);
    check("gnt1", bus.gnt1, w == 1);
    ea  = (w == 0) ? bus.addr0 : (w == 1) ? bus.addr1 : '0;
    ed  = (w == 0) ? bus.wdata0 : (w == 1) ? bus.wdata1 : '0;
    ewe = (w == 0) ? bus.we0 : (w == 1) ? bus.we1 : 1'b0;
    check("mem_addr", bus.mem_addr, ea);
    check("mem_wdata", bus.mem_wdata, ed);
    check("mem_wren", bus.mem_wren, ewe);
    if (w >= 0) begin
      if (ewe) ref_mem[ea[7:0]] = ed;
      else sb.push_back('{cyc + 1, (w == 1), ref_mem[ea[7:0]]});
    end
    if (bus.req0 && w != 0) wait0++;
    else if (w == 0) begin
      check("starve0", wait0 <= LockMax + 1, 1'b1);
      wait0 = 0;
    end
    if (bus.req1 && w != 1) wait1++;
    else if (w == 1) begin
      check("starve1", wait1 <= LockMax + 1, 1'b1);
      wait1 = 0;
    end
    model_update(w, bus.lock1);
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  always @(negedge clk) begin
    bit   e0, e1;
    rd_t  rd;
    e0 = 0;
    e1 = 0;
    if (reset) begin
      last0 = '0;
      last1 = '0;
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      rd = sb.pop_front();
      check("rd_late", 1'b0, 1'b1);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      rd = sb.pop_front();
      e0 = !rd.owner;
      e1 = rd.owner;
      if (e0) last0 = rd.data;
      else last1 = rd.data;
    end
    check("rvalid0", bus.rvalid0, e0);
    check("rvalid1", bus.rvalid1, e1);
    check("rdata0", bus.rdata0, last0);
    check("rdata1", bus.rdata1, last1);
  end

  task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit r1, input bit w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit l1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.lock1 = l1;
  endtask

  initial begin
    int w;
    int seq [20];
    int burst;
    bit p0, p1;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end

    // Reset with both requesters active: every output must be held at zero
    reset = 1'b1;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_gnt0", bus.gnt0, 1'b0);
    check("rst_gnt1", bus.gnt1, 1'b0);
    check("rst_wren", bus.mem_wren, 1'b0);
    check("rst_addr", bus.mem_addr, '0);
    check("rst_wdata", bus.mem_wdata, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Both reading: alternating grants, requester 0 first
    for (int i = 0; i < 4; i++) begin
      step(w);
      seq[i] = w;
    end
    check("p1_order", {seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]}, 8'b00010001);

    // Write then read back
    drive(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(w);
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    step(w);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("p2_rvalid0", bus.rvalid0, 1'b1);
    check("p2_rdata0", bus.rdata0, 32'hDEADBEEF);
    step(w);

    // Locked burst with requester 0 waiting
    drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(w);
      seq[i] = w;
    end
    burst = 0;
    while (burst < 20 && seq[burst] == 1) burst++;
    check("p3_burst", burst, 16);
    check("p3_force", seq[16], 0);
    check("p3_relock", {seq[17][1:0], seq[18][1:0], seq[19][1:0]}, 6'b010101);

    // Idle bubble holds the lock, then dropping the lock hands over to requester 0
    drive(1, 0, 32'h10, 0, 0, 0, 32'h20, 0, 1);
    step(w);
    check("p4_bubble", w, -1);
    drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 1);
    step(w);
    check("p4_locked", w, 1);
    drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
    step(w);
    check("p4_drop", w, 0);
    step(w);
    check("p4_rr1", w, 1);
    step(w);
    check("p4_rr0", w, 0);

    // Reset right after a granted read: the read is dropped
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    step(w);
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("p5_rvalid0", bus.rvalid0, 1'b0);
    check("p5_rdata0", bus.rdata0, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(w);
    check("p5_after", {bus.rvalid0, bus.rvalid1}, 2'b00);

    // Random traffic; an ungranted request is held stable
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!p0) begin
        bus.req0   = ($urandom_range(0, 3) != 0);
        bus.we0    = $urandom_range(0, 1);
        bus.addr0  = $urandom_range(0, 31);
        bus.wdata0 = $urandom;
      end
      if (!p1) begin
        bus.req1   = ($urandom_range(0, 3) != 0);
        bus.we1    = $urandom_range(0, 1);
        bus.addr1  = $urandom_range(0, 31);
        bus.wdata1 = $urandom;
      end
      bus.lock1 = bus.req1 && ($urandom_range(0, 3) != 0);
      step(w);
      p0 = bus.req0 && (w != 0);
      p1 = bus.req1 && (w != 1);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(w);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: requester 0 (core load/store path) and requester 1 (debug/loader port for program/data preload and inspection).
- Sits between the requesters and the data memory.
- Performs round-robin arbitration, with an optional lock so requester 1 can run bursts.
- Returns read data one cycle after the access is granted and routes it to the requester that issued the read.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LOCK_MAX, 16, maximum consecutive locked grants to requester 1 before requester 0 is forced a grant; 0 disables the limit.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write enable (0 = read).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  requester 0 granted this cycle (combinational).
- rvalid0  out  1  requester 0 read data valid.
- rdata0  out  DW  requester 0 read data.
- req1, we1, addr1, wdata1  in  1/1/AW/DW  requester 1 equivalents.
- lock1  in  1  requester 1 requests to hold ownership after its grant.
- gnt1  out  1  requester 1 granted this cycle.
- rvalid1  out  1  requester 1 read data valid.
- rdata1  out  DW  requester 1 read data.
- mem_wren  out  1  write enable to data memory.
- mem_addr  out  AW  address to data memory.
- mem_wdata  out  DW  write data to data memory.
- mem_rdata  in  DW  data memory read data, valid one cycle after the address is presented (registered read).

Behaviour:
- Reset (async, active-high):
  - state = RR, last = 1 (requester 0 wins the first tie), lock_cnt = 0, rd_pend = 0, rd_owner = 0.
  - gnt0 = gnt1 = 0; rvalid0 = rvalid1 = 0; rdata0 = rdata1 = 0.
  - mem_wren = 0; mem_addr and mem_wdata = 0.
- State RR:
  - Only one request asserted: that requester is granted.
  - Both asserted: grant the requester that is not `last`.
  - On any grant: `last` <= winner at the clock edge.
  - Requester 1 granted with lock1 = 1: next state LOCKED, lock_cnt <= 1.
- State LOCKED:
  - gnt1 = req1 and gnt0 = 0 while lock1 = 1 and (LOCK_MAX = 0 or lock_cnt < LOCK_MAX).
  - lock_cnt increments on each locked grant.
  - lock1 = 0: return to RR the same cycle, arbitrating as in RR with last = 1.
  - lock_cnt reaching LOCK_MAX with req0 pending: requester 0 is granted, last <= 0, lock_cnt <= 0, state RR; requester 1 may re-lock at its next grant.
  - req1 = 0 while lock1 = 1: no grant; the lock is held (idle bubble).
- Grants are combinational from req/state. A request without a grant must be held stable by the requester until granted.
- Memory drive:
  - mem_addr, mem_wdata and mem_wren are combinational from the granted requester.
  - mem_wren = granted requester's we.
  - No grant: mem_wren = 0; mem_addr and mem_wdata hold 0.
  - At most one of gnt0/gnt1 is high in any cycle.
- Read return:
  - A granted read (we = 0) sets rd_pend = 1 and rd_owner = winner at the edge.
  - Next cycle: rvalid of rd_owner = 1 and its rdata = mem_rdata; the other rvalid = 0.
  - rdata of a requester holds its last value when its rvalid = 0.
  - Reads can be granted back-to-back; each returns exactly one cycle later, in grant order.
  - Writes produce no rvalid.
- Simultaneous events:
  - A new grant in the same cycle as a read return is allowed; the pipeline depth is 1.
  - Same-address write and read in consecutive cycles: the read returns memory contents after the write.
- Reset mid-operation: a pending read is dropped and no rvalid is issued after reset release.

Test Plan:
- Reset release with req0 = req1 = 1 reading addr0 = 0x10 and addr1 = 0x20 for 4 cycles → grants alternate 0,1,0,1; each rvalid pulses one cycle after its grant with mem[0x10] or mem[0x20].
- req0 only, write 0xDEADBEEF to 0x40, then read 0x40 → write cycle: mem_wren = 1, no rvalid; next read cycle: gnt0 = 1; the following cycle: rvalid0 = 1, rdata0 = 0xDEADBEEF.
- req1 with lock1 = 1 for 20 cycles, req0 held high, LOCK_MAX = 16 → gnt1 for 16 cycles, then gnt0 for exactly 1 cycle, then requester 1 re-locks.
- Locked burst with lock1 dropped at cycle 5 and req0 pending → gnt0 in cycle 5; state RR.
- Reset asserted the cycle after a granted read → rvalid0 and rvalid1 stay 0 after release; all outputs are 0 during reset.
- Random req/we/lock traffic for 10k cycles against a memory model → gnt0 and gnt1 are never both high; every read returns the model data to the correct owner with latency 1; no request starves beyond LOCK_MAX + 1 cycles.
